// File: rtl/paddle.sv
// paddle -- player bar controller for one side of the Pong game.
//
// Turns the up/down buttons into frame-synchronous vertical motion of the bar,
// with a velocity ramp (StartSpeed, +Accel per frame, capped at MaxSpeed) and
// clamping to the screen. All motion state changes on the single per-frame
// tick (xPos==0, yPos==sHeight), which lies outside the visible area, so the
// published edges are stable while the screen is being drawn.
//
// Optional feature: define PADDLE_AUTO_EN to add autoMode/ballYCentre. With
// autoMode=1 the bar tracks the ball directly, bypassing the button debounce.
//
// Ports:
//   PixelClock   in   pixel clock, all state on its rising edge
//   ResetN       in   synchronous reset, active-low
//   xPos, yPos   in   12-bit scan counters
//   upBtn        in   move-up request (asynchronous)
//   downBtn      in   move-down request (asynchronous)
//   autoMode     in   track the ball instead of the buttons (PADDLE_AUTO_EN)
//   ballYCentre  in   ball centre y coordinate (PADDLE_AUTO_EN)
//   barEdges     out  [0]=left, [1]=right, [2]=top, [3]=bottom
//   drawBar      out  scan position is inside the bar (inclusive)
//   moving       out  motion FSM is not IDLE
module paddle #(
  parameter int oLeft        = 10,
  parameter int oTop         = 225,
  parameter int oWidth       = 20,
  parameter int oHeight      = 150,
  parameter int sHeight      = 600,
  parameter int StartSpeed   = 2,
  parameter int Accel        = 1,
  parameter int MaxSpeed     = 8,
  parameter int AutoDeadband = 8
) (
  input  logic             PixelClock,
  input  logic             ResetN,
  input  logic [11:0]      xPos,
  input  logic [11:0]      yPos,
  input  logic             upBtn,
  input  logic             downBtn,
`ifdef PADDLE_AUTO_EN
  input  logic             autoMode,
  input  logic [10:0]      ballYCentre,
`endif
  output logic [3:0][10:0] barEdges,
  output logic             drawBar,
  output logic             moving
);

  typedef enum logic [1:0] {IDLE, ACCEL, CRUISE} state_t;
  typedef enum logic [1:0] {CMD_NONE, CMD_UP, CMD_DOWN} cmd_t;

  localparam logic [10:0]        StartV  = 11'(StartSpeed);
  localparam logic [10:0]        AccelV  = 11'(Accel);
  localparam logic [10:0]        MaxV    = 11'(MaxSpeed);
  localparam logic [10:0]        TopInit = 11'(oTop);
  localparam logic signed [11:0] MaxTop  = 12'(sHeight - oHeight);

  // Synchronizers, debounce and motion state.
  logic   up_meta, up_sync, down_meta, down_sync;
  cmd_t   samp, cmd, dir;
  state_t state;
  logic [10:0] top, vel;

  // Next-state values.
  cmd_t   samp_next, cmd_next, dir_next, raw;
  state_t state_next;
  logic [10:0] top_next, vel_next;

  logic tick;
  logic move;
  logic signed [11:0] cand;

  assign tick = (xPos == 12'd0) && (yPos == 12'(sHeight));

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    raw = CMD_NONE;
    if (up_sync && !down_sync)      raw = CMD_UP;
    else if (down_sync && !up_sync) raw = CMD_DOWN;
  end

  // Debounce: a command is accepted only when it was seen on two consecutive
  // ticks; anything shorter than a frame therefore never reaches the FSM.
  always_comb begin
    samp_next = samp;
    cmd_next  = cmd;
    if (tick) begin
      samp_next = raw;
      if (raw == samp) cmd_next = raw;
`ifdef PADDLE_AUTO_EN
      if (autoMode) begin
        logic [11:0] centre;
        centre   = {1'b0, top} + 12'(oHeight / 2);
        cmd_next = CMD_NONE;
        // ball < centre - deadband, written without a subtraction that could wrap
        if (({1'b0, ballYCentre} + 12'(AutoDeadband)) < centre)
          cmd_next = CMD_UP;
        else if ({1'b0, ballYCentre} > (centre + 12'(AutoDeadband)))
          cmd_next = CMD_DOWN;
      end
`endif
    end
  end

  // Motion FSM; uses the command accepted before this tick.
  always_comb begin
    state_next = state;
    vel_next   = vel;
    dir_next   = dir;
    top_next   = top;
    move       = 1'b0;
    if (tick) begin
      if (cmd == CMD_NONE) begin
        state_next = IDLE;
        vel_next   = '0;
      end else begin
        move     = 1'b1;
        dir_next = cmd;
        if (state == IDLE || cmd != dir) begin
          // Start or reversal: restart the ramp in the new direction.
          vel_next   = StartV;
          state_next = (StartV >= MaxV) ? CRUISE : ACCEL;
        end else if (state == ACCEL) begin
          vel_next   = ((vel + AccelV) >= MaxV) ? MaxV : (vel + AccelV);
          state_next = (vel_next == MaxV) ? CRUISE : ACCEL;
        end else begin
          vel_next   = MaxV;
          state_next = CRUISE;
        end
      end
    end

    // Signed so a move past the top wall shows up as negative, not as a wrap.
    cand = (dir_next == CMD_UP) ? (signed'({1'b0, top}) - signed'({1'b0, vel_next}))
                                : (signed'({1'b0, top}) + signed'({1'b0, vel_next}));

    if (move) begin
      if (cand < 12'sd0) begin
        top_next   = '0;
        state_next = IDLE;
        vel_next   = '0;
      end else if (cand > MaxTop) begin
        top_next   = MaxTop[10:0];
        state_next = IDLE;
        vel_next   = '0;
      end else begin
        top_next = cand[10:0];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge PixelClock) begin
    if (!ResetN) begin
      up_meta   <= 1'b0;
      up_sync   <= 1'b0;
      down_meta <= 1'b0;
      down_sync <= 1'b0;
      samp      <= CMD_NONE;
      cmd       <= CMD_NONE;
      dir       <= CMD_UP;
      state     <= IDLE;
      vel       <= '0;
      top       <= TopInit;
    end else begin
      up_meta   <= upBtn;
      up_sync   <= up_meta;
      down_meta <= downBtn;
      down_sync <= down_meta;
      samp      <= samp_next;
      cmd       <= cmd_next;
      dir       <= dir_next;
      state     <= state_next;
      vel       <= vel_next;
      top       <= top_next;
    end
  end

  always_comb begin
    barEdges[0] = 11'(oLeft);
    barEdges[1] = 11'(oLeft + oWidth - 1);
    barEdges[2] = top;
    barEdges[3] = top + 11'(oHeight - 1);
  end

  assign drawBar = (xPos >= {1'b0, barEdges[0]}) && (xPos <= {1'b0, barEdges[1]}) &&
                   (yPos >= {1'b0, barEdges[2]}) && (yPos <= {1'b0, barEdges[3]});

  assign moving = (state != IDLE);

endmodule

// File: tb/tb_paddle.sv
// Testbench for paddle: hand-computed vector tables for reset, drawBar bounds,
// the downward ramp and a reversal, plus behavioural-model sequences for the
// debounce, clamping and (when PADDLE_AUTO_EN is defined) auto-tracking cases.
module tb_paddle;

  logic             PixelClock = 1'b0;
  logic             ResetN;
  logic [11:0]      xPos, yPos;
  logic             upBtn, downBtn;
  logic [3:0][10:0] barEdges;
  logic             drawBar, moving;
`ifdef PADDLE_AUTO_EN
  logic             autoMode;
  logic [10:0]      ballYCentre;
`endif

  always #5 PixelClock = ~PixelClock;

  paddle dut (
    .PixelClock (PixelClock),
    .ResetN     (ResetN),
    .xPos       (xPos),
    .yPos       (yPos),
    .upBtn      (upBtn),
    .downBtn    (downBtn),
`ifdef PADDLE_AUTO_EN
    .autoMode   (autoMode),
    .ballYCentre(ballYCentre),
`endif
    .barEdges   (barEdges),
    .drawBar    (drawBar),
    .moving     (moving)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Scoreboard of expected post-tick state.
  typedef struct {
    string name;
    int    top;
    bit    mov;
  } exp_t;
  exp_t sb[$];

  // Behavioural model: bar is idle exactly when its speed is zero.
  int m_top, m_vel, m_dir, m_cmd, m_samp;  // cmd encoding: 0 none, 1 up, 2 down

  function automatic void model_reset();
    m_top = 225; m_vel = 0; m_dir = 1; m_cmd = 0; m_samp = 0;
  endfunction

  // forced >= 0 overrides the debounced command (auto mode).
  function automatic void model_tick(input bit up, input bit dn, input int forced);
    int raw, spd, nt;
    raw = (up && !dn) ? 1 : ((dn && !up) ? 2 : 0);
    if (m_cmd == 0) begin
      m_vel = 0;
    end else begin
      spd   = (m_vel == 0 || m_cmd != m_dir) ? 2 : ((m_vel + 1 > 8) ? 8 : m_vel + 1);
      m_dir = m_cmd;
      nt    = (m_dir == 1) ? m_top - spd : m_top + spd;
      if (nt < 0)        begin m_top = 0;   m_vel = 0;   end
      else if (nt > 450) begin m_top = 450; m_vel = 0;   end
      else               begin m_top = nt;  m_vel = spd; end
    end
    if (forced >= 0)        m_cmd = forced;
    else if (raw == m_samp) m_cmd = raw;
    m_samp = raw;
  endfunction

  // One frame: buttons settle through the synchronizers, then a single tick.
  task automatic run_frame(input bit up, input bit dn, input int forced,
                           input bit use_model, input int t_top, input bit t_mov,
                           input string name);
    exp_t e;
    @(negedge PixelClock);
    upBtn = up; downBtn = dn;
    repeat (4) @(negedge PixelClock);
    model_tick(up, dn, forced);
    e.name = name;
    e.top  = use_model ? m_top : t_top;
    e.mov  = use_model ? (m_vel != 0) : t_mov;
    sb.push_back(e);
    xPos = 12'd0; yPos = 12'd600;
    @(negedge PixelClock);
    xPos = 12'd1; yPos = 12'd0;
    e = sb.pop_front();
    check({e.name, "_top"},    int'(barEdges[2]), e.top);
    check({e.name, "_bottom"}, int'(barEdges[3]), e.top + 149);
    check({e.name, "_moving"}, int'(moving),      int'(e.mov));
  endtask

  typedef struct {
    int x;
    int y;
    bit draw;
  } draw_vec_t;

  typedef struct {
    bit up;
    bit dn;
    int top;
    bit mov;
  } frame_vec_t;

  initial begin
    draw_vec_t  dv[8];
    frame_vec_t fv[15];

    dv[0] = '{15, 300, 1'b1}; dv[1] = '{30, 300, 1'b0};
    dv[2] = '{10, 225, 1'b1}; dv[3] = '{29, 374, 1'b1};
    dv[4] = '{9,  300, 1'b0}; dv[5] = '{30, 374, 1'b0};
    dv[6] = '{20, 224, 1'b0}; dv[7] = '{20, 375, 1'b0};

    // Down held from idle: two debounce ticks, then the ramp into CRUISE.
    fv[0]  = '{1'b0, 1'b1, 225, 1'b0}; fv[1]  = '{1'b0, 1'b1, 225, 1'b0};
    fv[2]  = '{1'b0, 1'b1, 227, 1'b1}; fv[3]  = '{1'b0, 1'b1, 230, 1'b1};
    fv[4]  = '{1'b0, 1'b1, 234, 1'b1}; fv[5]  = '{1'b0, 1'b1, 239, 1'b1};
    fv[6]  = '{1'b0, 1'b1, 245, 1'b1}; fv[7]  = '{1'b0, 1'b1, 252, 1'b1};
    fv[8]  = '{1'b0, 1'b1, 260, 1'b1}; fv[9]  = '{1'b0, 1'b1, 268, 1'b1};
    // Switch to up: two more down frames while debouncing, then 2, 3, 4 up.
    fv[10] = '{1'b1, 1'b0, 276, 1'b1}; fv[11] = '{1'b1, 1'b0, 284, 1'b1};
    fv[12] = '{1'b1, 1'b0, 282, 1'b1}; fv[13] = '{1'b1, 1'b0, 279, 1'b1};
    fv[14] = '{1'b1, 1'b0, 275, 1'b1};

    ResetN = 1'b0; upBtn = 1'b0; downBtn = 1'b0;
    xPos = 12'd15; yPos = 12'd300;
`ifdef PADDLE_AUTO_EN
    autoMode = 1'b0; ballYCentre = 11'd0;
`endif
    model_reset();
    repeat (3) @(negedge PixelClock);

    check("rst_left",   int'(barEdges[0]), 10);
    check("rst_right",  int'(barEdges[1]), 29);
    check("rst_top",    int'(barEdges[2]), 225);
    check("rst_bottom", int'(barEdges[3]), 374);
    check("rst_moving", int'(moving), 0);
    ResetN = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge PixelClock);
      xPos = 12'(dv[i].x); yPos = 12'(dv[i].y);
      #1;
      check($sformatf("draw_%0d_%0d", dv[i].x, dv[i].y), int'(drawBar), int'(dv[i].draw));
    end

    for (int i = 0; i < 15; i++)
      run_frame(fv[i].up, fv[i].dn, -1, 1'b0, fv[i].top, fv[i].mov, $sformatf("ramp%0d", i));

    // Reset mid-ramp returns the bar to its start one clock later.
    @(negedge PixelClock);
    ResetN = 1'b0; upBtn = 1'b0;
    @(negedge PixelClock);
    check("midrst_top",    int'(barEdges[2]), 225);
    check("midrst_moving", int'(moving), 0);
    ResetN = 1'b1;
    model_reset();

    // 1000-clock pulse between ticks is never sampled.
    @(negedge PixelClock);
    upBtn = 1'b1;
    repeat (1000) @(negedge PixelClock);
    upBtn = 1'b0;
    for (int i = 0; i < 2; i++) run_frame(1'b0, 1'b0, -1, 1'b1, 0, 1'b0, $sformatf("glitch%0d", i));

    // A pulse seen on only one tick is rejected.
    run_frame(1'b1, 1'b0, -1, 1'b1, 0, 1'b0, "onetick0");
    for (int i = 0; i < 2; i++) run_frame(1'b0, 1'b0, -1, 1'b1, 0, 1'b0, $sformatf("onetick%0d", i + 1));

    // Both buttons: no command.
    for (int i = 0; i < 4; i++) run_frame(1'b1, 1'b1, -1, 1'b1, 0, 1'b0, $sformatf("both%0d", i));

    // Hold up into the top wall and keep holding.
    for (int i = 0; i < 40; i++) run_frame(1'b1, 1'b0, -1, 1'b1, 0, 1'b0, $sformatf("clup%0d", i));
    check("clup_final_top", int'(barEdges[2]), 0);
    check("clup_final_moving", int'(moving), 0);

    // Hold down into the bottom wall.
    for (int i = 0; i < 70; i++) run_frame(1'b0, 1'b1, -1, 1'b1, 0, 1'b0, $sformatf("cldn%0d", i));
    check("cldn_final_top", int'(barEdges[2]), 450);
    check("cldn_final_moving", int'(moving), 0);

`ifdef PADDLE_AUTO_EN
    @(negedge PixelClock);
    ResetN = 1'b0; downBtn = 1'b0; upBtn = 1'b0;
    @(negedge PixelClock);
    ResetN = 1'b1;
    model_reset();
    autoMode = 1'b1;
    ballYCentre = 11'd305;  // inside the deadband around centre 300
    for (int i = 0; i < 3; i++) run_frame(1'b0, 1'b0, 0, 1'b0, 225, 1'b0, $sformatf("auto_db%0d", i));
    ballYCentre = 11'd100;
    run_frame(1'b0, 1'b0, 1, 1'b0, 225, 1'b0, "auto_up0");
    run_frame(1'b0, 1'b0, 1, 1'b0, 223, 1'b1, "auto_up1");
    run_frame(1'b0, 1'b0, 1, 1'b0, 220, 1'b1, "auto_up2");
    autoMode = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
